// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: WIDTH-bit carry chain split into SEGS registered segments, valid/ready both sides.
// Optional signed saturation on overflow when PIPELINED_ADDER_SATURATE_EN is defined.
module pipelined_adder #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned SEGS  = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             cout,
   output logic             ovf
);

   localparam int unsigned SW   = WIDTH / SEGS;
   localparam int unsigned LAST = SEGS - 1;

   if (SEGS < 1 || SEGS > WIDTH || (WIDTH % SEGS) != 0) begin : g_bad_cfg
      $error("pipelined_adder: need 1 <= SEGS <= WIDTH and WIDTH a multiple of SEGS");
   end

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   // Stage k holds the operand bits not yet added plus the low sum bits already produced.
   for (genvar k = 0; k < SEGS; k++) begin : stg
      localparam int unsigned LO = k * SW;
      localparam int unsigned HI = WIDTH - LO;

      logic [HI-1:0]    q_a;
      logic [HI-1:0]    q_b;
      logic             q_c;
      logic             q_v;
`ifdef PIPELINED_ADDER_SATURATE_EN
      logic             q_sat;
`endif
      logic [SW:0]      seg;
      logic [LO+SW-1:0] s_out;

      assign seg = {1'b0, q_a[SW-1:0]} + {1'b0, q_b[SW-1:0]} + (SW+1)'(q_c);

      if (k == 0) begin : g_head
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               q_v   <= 1'b0;
               q_c   <= 1'b0;
               q_a   <= '0;
               q_b   <= '0;
`ifdef PIPELINED_ADDER_SATURATE_EN
               q_sat <= 1'b0;
`endif
            end else if (advance) begin
               q_v   <= in_valid;
               q_c   <= sub | cin;
               q_a   <= a;
               q_b   <= sub ? ~b : b;
`ifdef PIPELINED_ADDER_SATURATE_EN
               q_sat <= sat;
`endif
            end
         end
         assign s_out = seg[SW-1:0];
      end else begin : g_body
         logic [LO-1:0] q_s;

         always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
               q_v   <= 1'b0;
               q_c   <= 1'b0;
               q_a   <= '0;
               q_b   <= '0;
               q_s   <= '0;
`ifdef PIPELINED_ADDER_SATURATE_EN
               q_sat <= 1'b0;
`endif
            end else if (advance) begin
               q_v   <= stg[k-1].q_v;
               q_c   <= stg[k-1].seg[SW];
               q_a   <= stg[k-1].q_a[HI+SW-1:SW];
               q_b   <= stg[k-1].q_b[HI+SW-1:SW];
               q_s   <= stg[k-1].s_out;
`ifdef PIPELINED_ADDER_SATURATE_EN
               q_sat <= stg[k-1].q_sat;
`endif
            end
         end
         assign s_out = {seg[SW-1:0], q_s};
      end
   end

   logic             ovf_c;
   logic [WIDTH-1:0] res_c;

   // In the last stage q_a/q_b hold only the top segment, so their MSB is the operand sign.
   assign ovf_c = (stg[LAST].q_a[SW-1] == stg[LAST].q_b[SW-1]) &&
                  (stg[LAST].s_out[WIDTH-1] != stg[LAST].q_a[SW-1]);

`ifdef PIPELINED_ADDER_SATURATE_EN
   assign res_c = (stg[LAST].q_sat && ovf_c)
                ? (stg[LAST].q_a[SW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}})
                : stg[LAST].s_out;
`else
   logic unused_sat;
   assign unused_sat = sat;
   assign res_c      = stg[LAST].s_out;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         out_valid <= 1'b0;
         result    <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (advance) begin
         out_valid <= stg[LAST].q_v;
         result    <= res_c;
         cout      <= stg[LAST].seg[SW];
         ovf       <= ovf_c;
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder (WIDTH=16, SEGS=4): directed corner cases, stall, reset flush and random traffic
// scored against an arithmetic reference model; honours PIPELINED_ADDER_SATURATE_EN.
module tb_pipelined_adder;

   localparam int unsigned W = 16;
   localparam int unsigned S = 4;

`ifdef PIPELINED_ADDER_SATURATE_EN
   localparam bit           SAT_EN = 1'b1;
   localparam logic [W-1:0] T4A_R  = 16'h7FFF;
   localparam logic [W-1:0] T4B_R  = 16'h8000;
`else
   localparam bit           SAT_EN = 1'b0;
   localparam logic [W-1:0] T4A_R  = 16'h8000;
   localparam logic [W-1:0] T4B_R  = 16'h7FFF;
`endif

   typedef struct packed {
      logic [W-1:0] r;
      logic         c;
      logic         o;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset, in_valid, in_ready, cin, sub, sat;
   logic         out_valid, out_ready, cout, ovf;
   logic [W-1:0] a, b, result;

   int           n_checks = 0;
   int           n_fail   = 0;
   exp_t         q[$];
   logic         use_exp = 1'b0;
   exp_t         exp_next;
   logic         stalled_prev = 1'b0;
   logic [W+2:0] held = '0;

   pipelined_adder #(.WIDTH(W), .SEGS(S)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .sat       (sat),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .cout      (cout),
      .ovf       (ovf)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic exp_t model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                  input logic icin, input logic isub, input logic isat);
      longint ua, ub, sa, sb, full, sv, maxv, minv;
      exp_t   e;
      ua   = longint'(ia);
      ub   = longint'(ib);
      sa   = longint'($signed(ia));
      sb   = longint'($signed(ib));
      maxv = (longint'(1) << (W - 1)) - 1;
      minv = -(longint'(1) << (W - 1));
      if (isub) begin
         full = ua - ub;
         sv   = sa - sb;
         e.c  = (ua >= ub);
      end else begin
         full = ua + ub + longint'(icin);
         sv   = sa + sb + longint'(icin);
         e.c  = (full >= (longint'(1) << W));
      end
      e.r = W'(full);
      e.o = (sv > maxv) || (sv < minv);
      if (SAT_EN && isat && e.o) e.r = (sv > maxv) ? W'(maxv) : W'(minv);
      return e;
   endfunction

   function automatic logic [W-1:0] rnd_op();
      case ($urandom_range(0, 7))
         0:       return '0;
         1:       return '1;
         2:       return 16'h7FFF;
         3:       return 16'h8000;
         default: return W'($urandom);
      endcase
   endfunction

   // Scoreboard and stall monitor; inputs only change just after posedge, so negedge sees the edge-time values.
   always @(negedge clk) begin
      if (!reset) begin
         stalled_prev <= 1'b0;
      end else begin
         if (stalled_prev) check("stall_hold", 64'({out_valid, result, cout, ovf}), 64'(held));
         if (out_valid && !out_ready) check("in_ready_stall", 64'(in_ready), 64'(0));
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               check("spurious_out", 64'(out_valid), 64'(0));
            end else begin
               check("result", 64'(result), 64'(q[0].r));
               check("cout", 64'(cout), 64'(q[0].c));
               check("ovf", 64'(ovf), 64'(q[0].o));
               void'(q.pop_front());
            end
         end
         if (in_valid && in_ready) q.push_back(use_exp ? exp_next : model(a, b, cin, sub, sat));
         stalled_prev <= out_valid && !out_ready;
         held         <= {out_valid, result, cout, ovf};
      end
   end

   task automatic push(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                       input logic isub, input logic isat, output int edges);
      logic fire;
      edges    = 0;
      fire     = 1'b0;
      a        = ia;
      b        = ib;
      cin      = icin;
      sub      = isub;
      sat      = isat;
      in_valid = 1'b1;
      while (!fire && edges < 100) begin
         @(negedge clk);
         fire = in_ready;
         @(posedge clk);
         #1;
         edges++;
      end
      if (!fire) check("accept_timeout", 64'(0), 64'(1));
      in_valid = 1'b0;
   endtask

   task automatic single(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic icin,
                         input logic isub, input logic isat, input exp_t e, input string tag);
      int edges, cnt;
      use_exp  = 1'b1;
      exp_next = e;
      push(ia, ib, icin, isub, isat, edges);
      use_exp  = 1'b0;
      check({tag, "_accept"}, 64'(edges), 64'(1));
      cnt = 0;
      while (!out_valid && cnt < 50) begin
         @(posedge clk);
         #1;
         cnt++;
      end
      check({tag, "_latency"}, 64'(cnt), 64'(S));
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string tag);
      int t;
      out_ready = 1'b1;
      t = 0;
      while (q.size() != 0 && t < 200) begin
         @(posedge clk);
         #1;
         t++;
      end
      check(tag, 64'(q.size()), 64'(0));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int   total, edges;
      logic done;

      reset     = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      sat       = 1'b0;
      out_ready = 1'b1;
      #2 reset  = 1'b0;
      #1;
      check("rst_out_valid", 64'(out_valid), 64'(0));
      check("rst_result", 64'(result), 64'(0));
      check("rst_cout", 64'(cout), 64'(0));
      check("rst_ovf", 64'(ovf), 64'(0));
      check("rst_in_ready", 64'(in_ready), 64'(1));
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      // Directed corner cases with hand-computed results.
      single(16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, '{r: 16'hFFFF, c: 1'b0, o: 1'b0}, "t1");
      single(16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b0, '{r: 16'h0000, c: 1'b1, o: 1'b0}, "t2");
      single(16'h0005, 16'h0007, 1'b1, 1'b1, 1'b0, '{r: 16'hFFFE, c: 1'b0, o: 1'b0}, "t3");
      single(16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1, '{r: T4A_R, c: 1'b0, o: 1'b1}, "t4a");
      single(16'h8000, 16'hFFFF, 1'b0, 1'b0, 1'b1, '{r: T4B_R, c: 1'b1, o: 1'b1}, "t4b");
      single(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, '{r: 16'h7FFF, c: 1'b1, o: 1'b1}, "t_subovf");

      // Back-to-back stream with a 3-cycle output stall once results appear.
      total = 0;
      fork
         begin
            for (int i = 0; i < 8; i++) begin
               push(rnd_op(), rnd_op(), 1'(($urandom)), 1'(($urandom)), 1'(($urandom)), edges);
               total += edges;
            end
         end
         begin
            int t;
            t = 0;
            while (!out_valid && t < 50) begin
               @(negedge clk);
               t++;
            end
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      check("stream_edges", 64'(total), 64'(11));
      drain("drain_stream");

      // Reset with three items in flight: outputs clear at once and the items are never delivered.
      for (int i = 0; i < 3; i++) push(rnd_op(), rnd_op(), 1'b0, 1'b0, 1'b0, edges);
      reset = 1'b0;
      #1;
      check("flush_out_valid", 64'(out_valid), 64'(0));
      check("flush_result", 64'(result), 64'(0));
      check("flush_cout", 64'(cout), 64'(0));
      check("flush_ovf", 64'(ovf), 64'(0));
      q.delete();
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      single(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0, model(16'h1234, 16'h4321, 1'b1, 1'b0, 1'b0), "t6");

      // Random traffic with input gaps and random backpressure.
      done = 1'b0;
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               push(rnd_op(), rnd_op(), 1'(($urandom)), 1'(($urandom)), 1'(($urandom)), edges);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1 out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain("drain_random");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
